// File: rtl/cpu_out_monitor.sv
// Change-detecting capture of the core's CPUOut stream into a show-ahead FIFO
// with a valid/ready drain port and sticky overflow/drop statistics.
module cpu_out_monitor #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic [WIDTH-1:0]             CPUOut,
  input  logic                         Enable,
  input  logic                         Clear,
  output logic [WIDTH-1:0]             OutData,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Overflow,
  output logic [CNTW-1:0]              DropCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [WIDTH-1:0] prev;
  logic             prev_valid;
  logic             full;
  logic             capture;
  logic             pop;
  logic             push;
  logic             drop;

  // Full/empty come from Count so a full FIFO is not mistaken for empty.
  assign full     = (Count == CW'(DEPTH));
  assign OutValid = (Count != '0);
  assign capture  = Enable && (!prev_valid || (CPUOut != prev));
  assign pop      = OutValid && OutReady;
  assign push     = capture && (!full || pop);
  assign drop     = capture && !push;
  assign OutData  = mem[rd_ptr];

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !Clear) begin
      mem[wr_ptr] <= CPUOut;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      Count      <= '0;
      Overflow   <= 1'b0;
      DropCount  <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (Clear) begin
      // Clear wins over this cycle's push, pop and capture; prev is left as-is.
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      Count      <= '0;
      Overflow   <= 1'b0;
      DropCount  <= '0;
      prev_valid <= 1'b0;
    end else begin
      if (capture) begin
        prev       <= CPUOut;
        prev_valid <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      Count <= Count + 1'b1;
      else if (pop && !push) Count <= Count - 1'b1;
      if (drop) begin
        Overflow <= 1'b1;
        if (DropCount != '1) DropCount <= DropCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_out_monitor.sv
// Scoreboard bench for cpu_out_monitor: a reference model queue tracks expected
// FIFO contents and statistics; a second instance with CNTW=4 checks saturation.
module tb_cpu_out_monitor;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic              CLK = 1'b0;
  logic              Reset;
  logic [WIDTH-1:0]  CPUOut;
  logic              Enable;
  logic              Clear;
  logic              OutReady;
  logic [WIDTH-1:0]  OutData;
  logic              OutValid;
  logic [3:0]        Count;
  logic              Overflow;
  logic [15:0]       DropCount;
  logic [WIDTH-1:0]  od4;
  logic              ov4;
  logic [3:0]        cnt4;
  logic              ovf4;
  logic [3:0]        dc4;

  int asserts  = 0;
  int failures = 0;

  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] m_prev;
  bit               m_pv;
  bit               m_ovf;
  int               m_drops;

  cpu_out_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(16)) dut (
    .CLK(CLK), .Reset(Reset), .CPUOut(CPUOut), .Enable(Enable), .Clear(Clear),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady), .Count(Count),
    .Overflow(Overflow), .DropCount(DropCount)
  );

  cpu_out_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(4)) dut4 (
    .CLK(CLK), .Reset(Reset), .CPUOut(CPUOut), .Enable(Enable), .Clear(Clear),
    .OutData(od4), .OutValid(ov4), .OutReady(OutReady), .Count(cnt4),
    .Overflow(ovf4), .DropCount(dc4)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of stimulus, advance the reference model, sample #1 after the edge.
  task automatic cycle(input logic [WIDTH-1:0] d, input logic en, input logic rdy,
                       input logic clr);
    logic cap;
    CPUOut = d; Enable = en; OutReady = rdy; Clear = clr;
    cap = en && (!m_pv || d != m_prev);
    if (clr) begin
      sb.delete(); m_pv = 1'b0; m_ovf = 1'b0; m_drops = 0;
    end else begin
      if (rdy && sb.size() > 0) void'(sb.pop_front());
      if (cap) begin
        m_prev = d; m_pv = 1'b1;
        if (sb.size() < DEPTH) sb.push_back(d);
        else begin m_ovf = 1'b1; m_drops++; end
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic model_reset();
    sb.delete(); m_prev = '0; m_pv = 1'b0; m_ovf = 1'b0; m_drops = 0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; CPUOut = '0; Enable = 1'b0; Clear = 1'b0; OutReady = 1'b0;
    model_reset();
    #2;
    asserts++;
    if (OutValid !== 1'b0 || Count !== 4'd0 || OutData !== '0 || DropCount !== '0 || Overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_init: valid=%b count=%0d data=%h drops=%0d ovf=%b, expected all zero",
               OutValid, Count, OutData, DropCount, Overflow);
    end
    #10 Reset = 1'b1;
    for (int i = 0; i < 5; i++) cycle(32'h1000 + i, 1'b1, 1'b0, 1'b0);
    asserts++;
    if (Count !== 4'(sb.size())) begin
      failures++; $display("FAIL reset_fill: count=%0d expected %0d", Count, sb.size());
    end
    #2 Reset = 1'b0;
    model_reset();
    #1;
    asserts++;
    if (OutValid !== 1'b0 || Count !== 4'd0 || DropCount !== '0 || OutData !== '0) begin
      failures++;
      $display("FAIL reset_async: valid=%b count=%0d drops=%0d data=%h, expected 0/0/0/0",
               OutValid, Count, DropCount, OutData);
    end
    #2 Reset = 1'b1;
    cycle('0, 1'b1, 1'b0, 1'b0);
    asserts++;
    if (Count !== 4'd1 || OutValid !== 1'b1 || OutData !== '0) begin
      failures++;
      $display("FAIL reset_first_capture: count=%0d valid=%b data=%h, expected 1/1/0",
               Count, OutValid, OutData);
    end
  endtask

  task automatic test_change_detect();
    logic [WIDTH-1:0] vals [5] = '{32'h83, 32'h83, 32'h83, 32'h10, 32'h10};
    logic [WIDTH-1:0] exp_vals [2] = '{32'h83, 32'h10};
    cycle('0, 1'b0, 1'b0, 1'b1);
    foreach (vals[i]) cycle(vals[i], 1'b1, 1'b0, 1'b0);
    asserts++;
    if (Count !== 4'd2) begin
      failures++; $display("FAIL change_count: count=%0d expected 2", Count);
    end
    for (int i = 0; i < 2; i++) begin
      asserts++;
      if (OutValid !== 1'b1 || OutData !== exp_vals[i] || OutData !== sb[0]) begin
        failures++;
        $display("FAIL change_pop%0d: valid=%b data=%h expected 1/%h", i, OutValid, OutData, exp_vals[i]);
      end
      cycle(32'h10, 1'b1, 1'b1, 1'b0);
    end
    asserts++;
    if (OutValid !== 1'b0 || Count !== 4'd0) begin
      failures++; $display("FAIL change_empty: valid=%b count=%0d expected 0/0", OutValid, Count);
    end
  endtask

  task automatic test_overflow();
    cycle('0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) cycle(32'(i), 1'b1, 1'b0, 1'b0);
    asserts++;
    if (Count !== 4'd8 || Overflow !== 1'b1 || DropCount !== 16'd2 || DropCount !== 16'(m_drops)) begin
      failures++;
      $display("FAIL overflow_state: count=%0d ovf=%b drops=%0d expected 8/1/2", Count, Overflow, DropCount);
    end
    for (int i = 1; i <= 8; i++) begin
      asserts++;
      if (OutValid !== 1'b1 || OutData !== 32'(i) || OutData !== sb[0]) begin
        failures++;
        $display("FAIL overflow_drain%0d: valid=%b data=%h expected 1/%h", i, OutValid, OutData, 32'(i));
      end
      cycle(32'd10, 1'b1, 1'b1, 1'b0);
    end
    asserts++;
    if (OutValid !== 1'b0 || Overflow !== 1'b1 || Overflow !== m_ovf) begin
      failures++; $display("FAIL overflow_sticky: valid=%b ovf=%b expected 0/1", OutValid, Overflow);
    end
  endtask

  task automatic test_back_to_back();
    cycle('0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(32'd100 + i, 1'b1, 1'b0, 1'b0);
    asserts++;
    if (Count !== 4'd8) begin
      failures++; $display("FAIL b2b_fill: count=%0d expected 8", Count);
    end
    for (int i = 0; i < 20; i++) begin
      asserts++;
      if (sb.size() == 0 || OutData !== sb[0]) begin
        failures++;
        $display("FAIL b2b_order%0d: data=%h expected %h", i, OutData, sb.size() ? sb[0] : 'x);
      end
      cycle(32'd200 + i, 1'b1, 1'b1, 1'b0);
      asserts++;
      if (Count !== 4'd8) begin
        failures++; $display("FAIL b2b_count%0d: count=%0d expected 8", i, Count);
      end
    end
    asserts++;
    if (DropCount !== 16'd0 || Overflow !== 1'b0) begin
      failures++; $display("FAIL b2b_drops: drops=%0d ovf=%b expected 0/0", DropCount, Overflow);
    end
  endtask

  task automatic test_clear_priority();
    cycle('0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cycle(32'd300 + i, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(32'd311, 1'b0, 1'b1, 1'b0);
    asserts++;
    if (Count !== 4'd3 || DropCount !== 16'd4 || Count !== 4'(sb.size())) begin
      failures++; $display("FAIL clear_setup: count=%0d drops=%0d expected 3/4", Count, DropCount);
    end
    cycle(32'd400, 1'b1, 1'b1, 1'b1);
    asserts++;
    if (Count !== 4'd0 || Overflow !== 1'b0 || DropCount !== 16'd0 || OutValid !== 1'b0) begin
      failures++;
      $display("FAIL clear_state: count=%0d ovf=%b drops=%0d valid=%b expected all 0",
               Count, Overflow, DropCount, OutValid);
    end
    cycle(32'd400, 1'b1, 1'b0, 1'b0);
    asserts++;
    if (Count !== 4'd1 || OutData !== 32'd400 || OutData !== sb[0]) begin
      failures++; $display("FAIL clear_recapture: count=%0d data=%0d expected 1/400", Count, OutData);
    end
  endtask

  task automatic test_enable_gating();
    cycle('0, 1'b0, 1'b0, 1'b1);
    cycle(32'h55, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(32'hA0 + i, 1'b0, 1'b0, 1'b0);
    asserts++;
    if (Count !== 4'd1 || Count !== 4'(sb.size())) begin
      failures++; $display("FAIL enable_low: count=%0d expected 1", Count);
    end
    cycle(32'h55, 1'b1, 1'b0, 1'b0);
    asserts++;
    if (Count !== 4'd1) begin
      failures++; $display("FAIL enable_same: count=%0d expected 1", Count);
    end
    cycle(32'h66, 1'b1, 1'b0, 1'b0);
    asserts++;
    if (Count !== 4'd2) begin
      failures++; $display("FAIL enable_new: count=%0d expected 2", Count);
    end
    cycle(32'h77, 1'b0, 1'b1, 1'b0);
    asserts++;
    if (Count !== 4'd1 || OutData !== 32'h66) begin
      failures++; $display("FAIL enable_pop: count=%0d data=%h expected 1/66", Count, OutData);
    end
  endtask

  task automatic test_saturation();
    cycle('0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 28; i++) cycle(32'd500 + i, 1'b1, 1'b0, 1'b0);
    asserts++;
    if (dc4 !== 4'd15 || ovf4 !== 1'b1 || cnt4 !== 4'd8) begin
      failures++; $display("FAIL sat_cntw4: drops=%0d ovf=%b count=%0d expected 15/1/8", dc4, ovf4, cnt4);
    end
    asserts++;
    if (DropCount !== 16'd20 || DropCount !== 16'(m_drops)) begin
      failures++; $display("FAIL sat_cntw16: drops=%0d expected 20", DropCount);
    end
  endtask

  initial begin
    test_reset();
    test_change_detect();
    test_overflow();
    test_back_to_back();
    test_clear_priority();
    test_enable_gating();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/cpu_out_monitor.md
# cpu_out_monitor

Buffers the value stream on the single-cycle core's `CPUOut` port so the outputs are not lost when a consumer cannot accept them immediately. The block sits directly downstream of `risc_v` and samples `CPUOut` on every clock. Each new value (a change from the last one seen) is pushed into a show-ahead FIFO. A valid/ready port drains the FIFO, and sticky overflow/drop statistics are kept for debug.

## Interface
- `WIDTH`, 32, data width; matches `CPUOut`.
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `CNTW`, 16, width of the drop counter.

- `CLK`  in  1  single clock, rising-edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `CPUOut`  in  WIDTH  core output value, sampled every rising edge.
- `Enable`  in  1  capture enable; when low, no captures happen and the history register holds.
- `Clear`  in  1  synchronous flush of FIFO, history and statistics.
- `OutData`  out  WIDTH  FIFO head entry (show-ahead).
- `OutValid`  out  1  FIFO non-empty.
- `OutReady`  in  1  consumer accepts the head entry this cycle.
- `Count`  out  $clog2(DEPTH+1)  current occupancy.
- `Overflow`  out  1  sticky; set when any capture is dropped.
- `DropCount`  out  CNTW  dropped captures; saturates at all-ones.

## Operation
**History register.**
- Holds `prev` (WIDTH bits) and `prev_valid` (1 bit).
- Capture condition: `Enable && (!prev_valid || CPUOut != prev)`.
- On capture, `prev` ← `CPUOut` and `prev_valid` ← 1. This happens even if the push is dropped.

**Pop and push.**
- Pop: `OutValid && OutReady`. `OutData` advances to the next entry on the following edge.
- Push: a capture is pushed when `Count < DEPTH`, or when `Count == DEPTH` and a pop happens in the same cycle.
- Otherwise the capture is dropped: `Overflow` ← 1 and `DropCount` increments, saturating at 2^CNTW−1.

**Empty FIFO.**
- A simultaneous capture and `OutReady` with the FIFO empty is a push only. No pop occurs.
- `Count` becomes 1.

**Pointers and occupancy.**
- Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- Full and empty are derived from `Count`, never from pointer equality alone.
- `Count` update per edge: +1 on push without pop, −1 on pop without push, unchanged on both or neither.

**Clear.**
- `Clear` high at an edge sets pointers, `Count`, `Overflow`, `DropCount` and `prev_valid` to 0.
- `Clear` has priority over push and pop in the same cycle; that cycle's capture is discarded and not counted as a drop.

**Enable low.**
- No pushes occur. Pops continue normally.
- `prev` is retained, so re-enabling with an unchanged `CPUOut` produces no capture.

## Timing
**Reset state.** While `Reset` is low, asynchronously:
- `OutValid`=0, `Count`=0, `Overflow`=0, `DropCount`=0, `OutData`=0.
- Pointers=0, `prev`=0, `prev_valid`=0.

**Latency.**
- A value on `CPUOut` before edge N is captured at edge N.
- Into an empty FIFO, `OutValid`=1 and `OutData`=value from just after edge N (1-cycle latency).

**Throughput.**
- One push and one pop per cycle.
- A full FIFO with `OutReady` held high accepts a capture every cycle with no drops.

**Output stability.**
- `OutData` and `OutValid` change only at rising edges or on reset assertion.
- `OutData` is stable while `OutValid && !OutReady`.

**Reset release.** Reset deassertion mid-stream resumes with empty state. The first enabled edge always captures, because `prev_valid`=0.

**Cleared-entry contents.** Unpopped entries are unspecified after reset or `Clear`. `OutData` equals entry[rd_ptr], and is 0 only at reset.

## Test plan
- **Reset.** Assert `Reset`=0 mid-operation with `Count`=5 → `OutValid`=0, `Count`=0 and `DropCount`=0 immediately, before the next edge.
- **Change detection.** `Enable`=1, `OutReady`=0; drive `CPUOut` 0x83, 0x83, 0x83, 0x10, 0x10 on successive edges → `Count`=2. Popping then yields 0x83 then 0x10.
- **Overflow.** `OutReady`=0; drive 10 distinct values 1..10 → `Count`=8, `Overflow`=1, `DropCount`=2. Draining yields 1..8 in order, and `Overflow` stays 1.
- **Full with pop.** Fill to 8, then hold `OutReady`=1 while pushing a new value each cycle for 20 cycles → `Count` stays 8, `DropCount`=0, and the output sequence is in order.
- **Clear priority.** Pulse `Clear` in the same cycle as a capture and a pop, with `Count`=3 and `DropCount`=4 → next cycle `Count`=0, `Overflow`=0, `DropCount`=0, `OutValid`=0. A following unchanged `CPUOut` is captured because history was reset.
- **Enable gating and saturation.**
  - `Enable`=0 while `CPUOut` toggles → no pushes.
  - Re-enabling with `CPUOut` equal to the last captured value → no push.
  - With `CNTW`=4, forcing 20 drops → `DropCount`=15.
